// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions.
// State encoding and default operand width.
package arith_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell.
// Computes a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // difference bit and borrow-out
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock.
// FSM, operand shifters, bit counter, borrow flop.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        bin_d  = fs_bout;
        if (cnt_q == LAST) begin
          borrow_d = fs_bout;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // register all state, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor.
// Hand-computed vectors, immediate assertions.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive a start pulse; returns just after the start edge (E0)
  task automatic kick(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = 8'h5A;
    b_i   = 8'hC3;
  endtask

  // count edges until done (bounded); also count busy samples
  task automatic wait_done(output int n, output int bn);
    n  = 0;
    bn = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bn++;
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    if (!done) n = 99;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ed,
                        input logic eb);
    int n;
    int bn;
    kick(av, bv);
    wait_done(n, bn);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy"}, bn, 8);
    chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    chk({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, {31'd0, done}, 0);
    chk({tag, "_hold"}, {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    int n;
    int bn;
    int extra;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_diff", {24'd0, diff}, 0);
    chk("rst_borrow", {31'd0, borrow}, 0);

    run_op("basic", 8'd100, 8'd37, 8'd63, 1'b0);
    run_op("under", 8'd5, 8'd9, 8'hFC, 1'b1);
    run_op("bound", 8'd0, 8'd1, 8'hFF, 1'b1);
    run_op("equal", 8'd255, 8'd255, 8'd0, 1'b0);
    run_op("zero", 8'd0, 8'd0, 8'd0, 1'b0);

    // start during SHIFT must be ignored
    kick(8'd10, 8'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    a_i   = 8'd1;
    b_i   = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 1);
    wait_done(n, bn);
    chk("ign_lat", 3 + n, 8);
    chk("ign_diff", {24'd0, diff}, 7);
    chk("ign_borrow", {31'd0, borrow}, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("ign_no2nd", extra, 0);

    // reset in the middle of an operation
    kick(8'd200, 8'd100);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_diff", {24'd0, diff}, 0);
    chk("mrst_borrow", {31'd0, borrow}, 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("mrst_nodone", extra, 0);

    run_op("fresh", 8'd50, 8'd20, 8'd30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
